// File: rtl/wgc_ferry_driver.sv
// -----------------------------------------------------------------------------
// wgc_ferry_driver
//
// Known-good stimulus source for the wolf/goat/cabbage river-crossing model.
// On start it replays a fixed 7-crossing safe solution, presenting one
// crossing (item select w/g/c) per valid/ready handshake. It keeps a shadow
// copy of which bank every actor is on and raises a sticky flag if that
// shadow state ever leaves one item alone with the item it would eat.
//
// Parameters:
//   ALT_SOLUTION  0: wolf on crossing 2, cabbage on crossing 4 (0-based step)
//                 1: cabbage on crossing 2, wolf on crossing 4
//
// Ports:
//   clk         clock, all state updates on posedge
//   rst         synchronous active-high reset
//   start       request a run (honoured in IDLE and DONE only)
//   move_valid  a crossing is presented on w/g/c
//   move_ready  consumer accepts the presented crossing
//   w, g, c     take wolf / goat / cabbage on this crossing (one-hot or none)
//   bank_w/g/c/p shadow bank of wolf / goat / cabbage / person
//   step        index of the crossing being presented, 0..6
//   busy        FSM in RUN
//   done        FSM in DONE
//   unsafe      sticky safety-violation flag, cleared only by rst
//
// Build option:
//   WGC_FORMAL_EN  when defined, immediate assert/assume/cover properties are
//                  compiled into a clocked process; function is unchanged.
// -----------------------------------------------------------------------------
module wgc_ferry_driver #(
    parameter bit ALT_SOLUTION = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       move_valid,
    input  logic       move_ready,
    output logic       w,
    output logic       g,
    output logic       c,
    output logic       bank_w,
    output logic       bank_g,
    output logic       bank_c,
    output logic       bank_p,
    output logic [2:0] step,
    output logic       busy,
    output logic       done,
    output logic       unsafe
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAST_STEP = 3'd6;

    // Item select {w,g,c} for a given crossing index of the chosen solution.
    function automatic logic [2:0] decode_sel(input logic [2:0] idx);
        logic [2:0] sel;
        case (idx)
            3'd0:    sel = 3'b010;
            3'd1:    sel = 3'b000;
            3'd2:    sel = ALT_SOLUTION ? 3'b001 : 3'b100;
            3'd3:    sel = 3'b010;
            3'd4:    sel = ALT_SOLUTION ? 3'b100 : 3'b001;
            3'd5:    sel = 3'b000;
            3'd6:    sel = 3'b010;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

    state_t     state_r;
    logic [2:0] step_r;
    logic       move_valid_r;
    logic       w_r;
    logic       g_r;
    logic       c_r;
    logic       bank_w_r;
    logic       bank_g_r;
    logic       bank_c_r;
    logic       bank_p_r;
    logic       busy_r;
    logic       done_r;
    logic       unsafe_r;

    logic       bank_w_nxt_s;
    logic       bank_g_nxt_s;
    logic       bank_c_nxt_s;
    logic       unsafe_cond_s;
    logic [2:0] sel_first_s;
    logic [2:0] sel_next_s;

    // Shadow bank update for a transfer: a selected item travels only if it
    // is on the same bank as the person, exactly as the puzzle model does.
    always_comb begin
        bank_w_nxt_s = bank_w_r;
        bank_g_nxt_s = bank_g_r;
        bank_c_nxt_s = bank_c_r;
        if (w_r && (bank_w_r == bank_p_r)) begin
            bank_w_nxt_s = !bank_p_r;
        end else begin
            bank_w_nxt_s = bank_w_r;
        end
        if (g_r && (bank_g_r == bank_p_r)) begin
            bank_g_nxt_s = !bank_p_r;
        end else begin
            bank_g_nxt_s = bank_g_r;
        end
        if (c_r && (bank_c_r == bank_p_r)) begin
            bank_c_nxt_s = !bank_p_r;
        end else begin
            bank_c_nxt_s = bank_c_r;
        end
    end

    // Unsafe when wolf+goat or goat+cabbage share a bank without the person.
    always_comb begin
        unsafe_cond_s = ((bank_w_r == bank_g_r) && (bank_w_r != bank_p_r)) ||
                        ((bank_g_r == bank_c_r) && (bank_g_r != bank_p_r));
    end

    // Selects for the first crossing of a run and for the crossing after step_r.
    always_comb begin
        sel_first_s = decode_sel(3'd0);
        sel_next_s  = decode_sel(step_r + 3'd1);
    end

    // Main FSM with registered handshake, select, shadow bank and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            step_r       <= 3'd0;
            move_valid_r <= 1'b0;
            w_r          <= 1'b0;
            g_r          <= 1'b0;
            c_r          <= 1'b0;
            bank_w_r     <= 1'b0;
            bank_g_r     <= 1'b0;
            bank_c_r     <= 1'b0;
            bank_p_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            unsafe_r     <= 1'b0;
        end else begin
            unsafe_r <= unsafe_r | unsafe_cond_s;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r            <= ST_RUN;
                        step_r             <= 3'd0;
                        move_valid_r       <= 1'b1;
                        {w_r, g_r, c_r}    <= sel_first_s;
                        busy_r             <= 1'b1;
                        done_r             <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // start is deliberately ignored while a run is in flight.
                    if (move_ready) begin
                        bank_w_r <= bank_w_nxt_s;
                        bank_g_r <= bank_g_nxt_s;
                        bank_c_r <= bank_c_nxt_s;
                        bank_p_r <= !bank_p_r;
                        if (step_r == LAST_STEP) begin
                            state_r         <= ST_DONE;
                            step_r          <= 3'd0;
                            move_valid_r    <= 1'b0;
                            {w_r, g_r, c_r} <= 3'b000;
                            busy_r          <= 1'b0;
                            done_r          <= 1'b1;
                        end else begin
                            step_r          <= step_r + 3'd1;
                            {w_r, g_r, c_r} <= sel_next_s;
                        end
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    step_r          <= 3'd0;
                    move_valid_r    <= 1'b0;
                    {w_r, g_r, c_r} <= 3'b000;
                    busy_r          <= 1'b0;
                    done_r          <= 1'b0;
                end
            endcase
        end
    end

`ifdef WGC_FORMAL_EN
    logic [2:0] stall_cnt_r;

    // Count consecutive stalls and check the driver's invariants each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 3'd0;
        end else begin
            if (move_valid_r && !move_ready && (stall_cnt_r != 3'd7)) begin
                stall_cnt_r <= stall_cnt_r + 3'd1;
            end else if (move_valid_r && !move_ready) begin
                stall_cnt_r <= stall_cnt_r;
            end else begin
                stall_cnt_r <= 3'd0;
            end
            assume (move_ready || (stall_cnt_r < 3'd4));
            assert (!unsafe_r);
            assert (({2'b00, w_r} + {2'b00, g_r} + {2'b00, c_r}) <= 3'd1);
            assert (!(!move_valid_r && (w_r | g_r | c_r)));
            cover (done_r && bank_w_r && bank_g_r && bank_c_r);
        end
    end
`endif

    assign move_valid = move_valid_r;
    assign w          = w_r;
    assign g          = g_r;
    assign c          = c_r;
    assign bank_w     = bank_w_r;
    assign bank_g     = bank_g_r;
    assign bank_c     = bank_c_r;
    assign bank_p     = bank_p_r;
    assign step       = step_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign unsafe     = unsafe_r;

endmodule

// File: tb/tb_wgc_ferry_driver.sv
// -----------------------------------------------------------------------------
// tb_wgc_ferry_driver
//
// Directed bench for wgc_ferry_driver. Two instances share the stimulus:
// dut0 uses the default solution, dut1 the alternate one. Every observation
// packs the outputs as
//   {move_valid, w, g, c, step[2:0], bank_w, bank_g, bank_c, bank_p,
//    busy, done, unsafe}
// and is compared against hand-computed tables.
// -----------------------------------------------------------------------------
module tb_wgc_ferry_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic move_ready = 1'b1;

    logic       mv0, w0, g0, c0, bw0, bg0, bc0, bp0, busy0, done0, uns0;
    logic [2:0] step0;
    logic       mv1, w1, g1, c1, bw1, bg1, bc1, bp1, busy1, done1, uns1;
    logic [2:0] step1;

    wgc_ferry_driver #(.ALT_SOLUTION(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start),
        .move_valid(mv0), .move_ready(move_ready),
        .w(w0), .g(g0), .c(c0),
        .bank_w(bw0), .bank_g(bg0), .bank_c(bc0), .bank_p(bp0),
        .step(step0), .busy(busy0), .done(done0), .unsafe(uns0)
    );

    wgc_ferry_driver #(.ALT_SOLUTION(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start),
        .move_valid(mv1), .move_ready(move_ready),
        .w(w1), .g(g1), .c(c1),
        .bank_w(bw1), .bank_g(bg1), .bank_c(bc1), .bank_p(bp1),
        .step(step1), .busy(busy1), .done(done1), .unsafe(uns1)
    );

    always #5 clk = ~clk;

    logic [13:0] obs0;
    logic [13:0] obs1;
    assign obs0 = {mv0, w0, g0, c0, step0, bw0, bg0, bc0, bp0, busy0, done0, uns0};
    assign obs1 = {mv1, w1, g1, c1, step1, bw1, bg1, bc1, bp1, busy1, done1, uns1};

    // Crossing selects {w,g,c} per step.
    localparam logic [2:0] SEQ0 [7] = '{3'b010, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000, 3'b010};
    localparam logic [2:0] SEQ1 [7] = '{3'b010, 3'b000, 3'b001, 3'b010, 3'b100, 3'b000, 3'b010};
    // Banks {w,g,c,p} while each step is presented, starting from home.
    localparam logic [3:0] BNK0 [7] = '{4'b0000, 4'b0101, 4'b0100, 4'b1101, 4'b1000, 4'b1011, 4'b1010};
    localparam logic [3:0] BNK1 [7] = '{4'b0000, 4'b0101, 4'b0100, 4'b0111, 4'b0010, 4'b1011, 4'b1010};

    localparam logic [13:0] IDLE_OBS  = 14'b0_000_000_0000_000;
    localparam logic [13:0] DONE_FAR  = 14'b0_000_000_1111_010;
    localparam logic [13:0] DONE_HOME = 14'b0_000_000_0000_010;

    int n_cmp = 0;
    int n_err = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        start = 1'b0;
        move_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (obs0 !== IDLE_OBS) begin
            n_err++;
            $display("FAIL reset_dut0: got %b expected %b", obs0, IDLE_OBS);
        end
        n_cmp++;
        if (obs1 !== IDLE_OBS) begin
            n_err++;
            $display("FAIL reset_dut1: got %b expected %b", obs1, IDLE_OBS);
        end
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (obs0 !== IDLE_OBS) begin
            n_err++;
            $display("FAIL idle_hold: got %b expected %b", obs0, IDLE_OBS);
        end
    endtask

    task automatic test_alt0_run;
        logic [13:0] exp;
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            exp = {1'b1, SEQ0[i], 3'(i), BNK0[i], 3'b100};
            n_cmp++;
            if (obs0 !== exp) begin
                n_err++;
                $display("FAIL alt0_step%0d: got %b expected %b", i, obs0, exp);
            end
            tick();
        end
        n_cmp++;
        if (obs0 !== DONE_FAR) begin
            n_err++;
            $display("FAIL alt0_done: got %b expected %b", obs0, DONE_FAR);
        end
    endtask

    task automatic test_replay;
        logic [13:0] exp;
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            exp = {1'b1, SEQ0[i], 3'(i), ~BNK0[i], 3'b100};
            n_cmp++;
            if (obs0 !== exp) begin
                n_err++;
                $display("FAIL replay_step%0d: got %b expected %b", i, obs0, exp);
            end
            tick();
        end
        n_cmp++;
        if (obs0 !== DONE_HOME) begin
            n_err++;
            $display("FAIL replay_done: got %b expected %b", obs0, DONE_HOME);
        end
    endtask

    task automatic test_alt1_run;
        logic [13:0] exp;
        do_reset();
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            exp = {1'b1, SEQ1[i], 3'(i), BNK1[i], 3'b100};
            n_cmp++;
            if (obs1 !== exp) begin
                n_err++;
                $display("FAIL alt1_step%0d: got %b expected %b", i, obs1, exp);
            end
            tick();
        end
        n_cmp++;
        if (obs1 !== DONE_FAR) begin
            n_err++;
            $display("FAIL alt1_done: got %b expected %b", obs1, DONE_FAR);
        end
    endtask

    task automatic test_stall;
        logic [13:0] exp;
        do_reset();
        pulse_start();
        repeat (3) tick();
        move_ready = 1'b0;
        exp = {1'b1, 3'b010, 3'd3, 4'b1101, 3'b100};
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (obs0 !== exp) begin
                n_err++;
                $display("FAIL stall_hold%0d: got %b expected %b", k, obs0, exp);
            end
            tick();
        end
        move_ready = 1'b1;
        for (int i = 3; i < 7; i++) begin
            exp = {1'b1, SEQ0[i], 3'(i), BNK0[i], 3'b100};
            n_cmp++;
            if (obs0 !== exp) begin
                n_err++;
                $display("FAIL stall_step%0d: got %b expected %b", i, obs0, exp);
            end
            tick();
        end
        n_cmp++;
        if (obs0 !== DONE_FAR) begin
            n_err++;
            $display("FAIL stall_done: got %b expected %b", obs0, DONE_FAR);
        end
    endtask

    task automatic test_midrun_reset;
        logic [13:0] exp;
        do_reset();
        pulse_start();
        repeat (4) tick();
        exp = {1'b1, SEQ0[4], 3'd4, BNK0[4], 3'b100};
        n_cmp++;
        if (obs0 !== exp) begin
            n_err++;
            $display("FAIL midrst_pre: got %b expected %b", obs0, exp);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (obs0 !== IDLE_OBS) begin
            n_err++;
            $display("FAIL midrst_idle: got %b expected %b", obs0, IDLE_OBS);
        end
        pulse_start();
        exp = {1'b1, 3'b010, 3'd0, 4'b0000, 3'b100};
        n_cmp++;
        if (obs0 !== exp) begin
            n_err++;
            $display("FAIL midrst_restart: got %b expected %b", obs0, exp);
        end
    endtask

    task automatic test_start_ignored;
        logic [13:0] exp;
        do_reset();
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            exp = {1'b1, SEQ0[i], 3'(i), BNK0[i], 3'b100};
            n_cmp++;
            if (obs0 !== exp) begin
                n_err++;
                $display("FAIL ign_step%0d: got %b expected %b", i, obs0, exp);
            end
            start = (i == 2);
            tick();
            start = 1'b0;
        end
        n_cmp++;
        if (obs0 !== DONE_FAR) begin
            n_err++;
            $display("FAIL ign_done: got %b expected %b", obs0, DONE_FAR);
        end
    endtask

    initial begin
        test_reset();
        test_alt0_run();
        test_replay();
        test_alt1_run();
        test_stall();
        test_midrun_reset();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
